// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, lane steering for stores,
// byte/halfword extraction with sign/zero extension for loads.
module load_store_unit #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_write_enable,
    output logic [3:0]        bus_mask_byte,
    output logic [31:0]       bus_write_data,
    input  logic [31:0]       bus_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              we_q, we_d;
    logic [3:0]        mask_q, mask_d;

    logic              req_legal;
    logic              req_misaligned;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic [3:0] lane_mask(input logic       wr,
                                             input logic [1:0] size,
                                             input logic [1:0] a);
        if (!wr) begin
            return 4'b1111;
        end
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // funct3[2] set means unsigned (LBU/LHU); the byte lane comes from addr[1:0].
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   return {{24{b[7] & ~f3[2]}}, b};
            2'b01:   return {{16{h[15] & ~f3[2]}}, h};
            default: return d;
        endcase
    endfunction

    always_comb begin
        req_legal = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                default:                req_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        we_d         = 1'b0;
        mask_d       = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDR_W+1:0];
                    wdata_d  = lane_data(req_funct3[1:0], req_wdata);
                    if (!req_legal || req_misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        state_d = ACCESS;
                        we_d    = req_write;
                        mask_d  = lane_mask(req_write, req_funct3[1:0], req_addr[1:0]);
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                end else begin
                    state_d = WAIT;
                    mask_d  = mask_q;
                end
            end
            WAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                rdata_d      = load_extract(funct3_q, addr_q[1:0], bus_read_data);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            we_q         <= we_d;
            mask_q       <= mask_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = rdata_q;
    assign bus_address      = addr_q[ADDR_W+1:2];
    assign bus_write_enable = we_q;
    assign bus_mask_byte    = mask_q;
    assign bus_write_data   = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the width of the word address driven on the data-memory bus.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: the core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I width/sign code.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load result.
REQ-012 SHALL have port resp_err, output, 1 bit: misaligned or illegal request; valid with resp_valid.
REQ-013 SHALL have port bus_address, output, ADDR_W bits: word address, equal to req_addr[ADDR_W+1:2].
REQ-014 SHALL have port bus_write_enable, output, 1 bit: memory write strobe.
REQ-015 SHALL have port bus_mask_byte, output, 4 bits: byte-lane enables.
REQ-016 SHALL have port bus_write_data, output, 32 bits: lane-aligned store data.
REQ-017 SHALL have port bus_read_data, input, 32 bits: memory word, valid one cycle after bus_address is driven.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge where req_valid=1 in IDLE, registering write, funct3, addr and wdata.
REQ-020 SHALL, for an accepted legal aligned request, go IDLE->ACCESS; a store then goes ACCESS->RESP and a load goes ACCESS->WAIT->RESP; RESP always returns to IDLE.
REQ-021 SHALL, for an accepted illegal or misaligned request, go IDLE->RESP directly with no bus_write_enable and resp_err=1.
REQ-022 SHALL treat as legal: loads with funct3 000 (LB), 001 (LH), 010 (LW), 100 (LBU), 101 (LHU); stores with funct3 000 (SB), 001 (SH), 010 (SW); every other code is illegal.
REQ-023 SHALL treat as misaligned: halfword with addr[0]=1, and word with addr[1:0]!=00.
REQ-024 SHALL drive bus_address from the registered address in ACCESS and WAIT; its value in other states is don't-care.
REQ-025 SHALL assert bus_write_enable only in ACCESS of a store, for exactly one cycle.
REQ-026 SHALL drive bus_mask_byte as follows: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; loads 1111; 0000 outside ACCESS/WAIT.
REQ-027 SHALL drive bus_write_data as follows: SB the byte replicated to all four lanes; SH the halfword replicated to both halves; SW unchanged.
REQ-028 SHALL capture bus_read_data at the end of WAIT, select byte lane addr[1:0] or halfword addr[1], and sign-extend (LB, LH) or zero-extend (LBU, LHU) into resp_rdata.
REQ-029 SHALL assert resp_valid for exactly one cycle in RESP; there is no response backpressure.
REQ-030 SHALL hold resp_rdata=0 for stores and errored requests, and hold it stable until the next RESP.
REQ-031 SHALL give fixed latency from the acceptance edge to resp_valid high: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-032 SHALL ignore req_valid outside IDLE; no request is queued.

Reset
REQ-033 SHALL, on rst=1 and without waiting for a clock edge, force state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, bus_write_enable=0 and bus_mask_byte=0000.
REQ-034 SHALL abort an in-flight request when reset is asserted mid-operation, with no response and no write after release.
REQ-035 SHALL set req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-036 SHALL pass this directed test: SW addr 0x0000_0010, data 0xDEADBEEF -> ACCESS cycle has bus_address=4, mask 1111, write_data 0xDEADBEEF, write_enable=1 for 1 cycle; resp_valid 2 cycles after acceptance with err=0.
REQ-037 SHALL pass this directed test: SB addr 0x13, data 0x000000A5 -> mask 1000, write_data 0xA5A5A5A5, bus_address=4.
REQ-038 SHALL pass this directed test: bus_read_data 0x80FF7F01; LB at 0x11 -> 0x0000007F; LB at 0x12 -> 0xFFFFFFFF; LBU at 0x13 -> 0x00000080; LH at 0x12 -> 0xFFFF80FF; LHU at 0x12 -> 0x000080FF; each with resp_valid 3 cycles after acceptance.
REQ-039 SHALL pass this directed test: LW at 0x12, SH at 0x11, and load funct3=011 -> resp_err=1 one cycle after acceptance, write_enable never asserted.
REQ-040 SHALL pass this directed test: rst pulsed during the ACCESS cycle of a store -> write_enable drops immediately, no resp_valid, req_ready=1 after release.
REQ-041 SHALL pass this directed test: back-to-back req_valid held high -> a new request is accepted only in IDLE, and req_valid seen in ACCESS/WAIT/RESP is ignored.
